// File: rtl/fft_mag_peak.sv
// Streaming |X[k]|^2 pipeline with a per-frame peak tracker.
// Three register stages: saturating abs, per-component square, and sum.
// The tracker searches a bin window and publishes the peak once the last bin (N-1) is seen.
module fft_mag_peak #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned INDEX_W = 7,
  parameter int unsigned MIN_BIN = 1,
  parameter int unsigned MAX_BIN = 63
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dv,
  input  logic [INDEX_W-1:0]        xk_index,
  input  logic signed [DATA_W-1:0]  xk_re,
  input  logic signed [DATA_W-1:0]  xk_im,
  output logic                      mag_valid,
  output logic [2*DATA_W-1:0]       mag,
  output logic [INDEX_W-1:0]        mag_index,
  output logic                      peak_valid,
  output logic [2*DATA_W-1:0]       peak_mag,
  output logic [INDEX_W-1:0]        peak_index,
  output logic [15:0]               frame_count
);

  localparam int unsigned AbsW = DATA_W - 1;
  localparam int unsigned SqW  = 2 * DATA_W - 2;
  localparam int unsigned MagW = 2 * DATA_W;

  localparam logic [INDEX_W-1:0] MinBin  = INDEX_W'(MIN_BIN);
  localparam logic [INDEX_W-1:0] MaxBin  = INDEX_W'(MAX_BIN);
  localparam logic [INDEX_W-1:0] LastBin = {INDEX_W{1'b1}};

  // Only the most-negative code stays negative after negation; clamp it to the
  // largest positive magnitude so every result fits in DATA_W-1 bits.
  function automatic logic [AbsW-1:0] sat_abs(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] neg;
    neg = -x;
    if (!x[DATA_W-1]) begin
      sat_abs = x[AbsW-1:0];
    end else if (neg[DATA_W-1]) begin
      sat_abs = {AbsW{1'b1}};
    end else begin
      sat_abs = neg[AbsW-1:0];
    end
  endfunction

  // Pipeline registers
  logic                 s1_valid_q, s2_valid_q, mag_valid_q;
  logic [INDEX_W-1:0]   s1_index_q, s2_index_q, mag_index_q;
  logic [AbsW-1:0]      re_abs_q, im_abs_q;
  logic [SqW-1:0]       re_sq_q, im_sq_q;
  logic [MagW-1:0]      mag_q;

  // Tracker and publication registers
  logic                 found_q, found_d;
  logic [MagW-1:0]      cur_max_q, cur_max_d;
  logic [INDEX_W-1:0]   cur_idx_q, cur_idx_d;
  logic                 frame_end;
  logic                 peak_valid_q;
  logic [MagW-1:0]      peak_mag_q;
  logic [INDEX_W-1:0]   peak_index_q;
  logic [15:0]          frame_count_q;

  // Three-stage abs / square / sum pipeline with its valid and index shadow
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      mag_valid_q <= 1'b0;
      s1_index_q  <= '0;
      s2_index_q  <= '0;
      mag_index_q <= '0;
      re_abs_q    <= '0;
      im_abs_q    <= '0;
      re_sq_q     <= '0;
      im_sq_q     <= '0;
      mag_q       <= '0;
    end else begin
      s1_valid_q  <= dv;
      s1_index_q  <= xk_index;
      re_abs_q    <= sat_abs(xk_re);
      im_abs_q    <= sat_abs(xk_im);
      s2_valid_q  <= s1_valid_q;
      s2_index_q  <= s1_index_q;
      re_sq_q     <= SqW'(re_abs_q) * SqW'(re_abs_q);
      im_sq_q     <= SqW'(im_abs_q) * SqW'(im_abs_q);
      mag_valid_q <= s2_valid_q;
      mag_index_q <= s2_index_q;
      mag_q       <= MagW'(re_sq_q) + MagW'(im_sq_q);
    end
  end

  // Evaluate the current stage-3 bin against the running maximum
  always_comb begin
    found_d   = found_q;
    cur_max_d = cur_max_q;
    cur_idx_d = cur_idx_q;
    frame_end = 1'b0;
    if (mag_valid_q) begin
      // Index 0 starts a new frame, even if the previous one never finished.
      if (mag_index_q == '0) begin
        found_d   = 1'b0;
        cur_max_d = '0;
        cur_idx_d = '0;
      end
      if ((mag_index_q >= MinBin) && (mag_index_q <= MaxBin) &&
          (!found_d || (mag_q > cur_max_d))) begin
        found_d   = 1'b1;
        cur_max_d = mag_q;
        cur_idx_d = mag_index_q;
      end
      frame_end = (mag_index_q == LastBin);
    end
  end

  // Tracker state, plus publication of the frame result when the last bin is evaluated
  always_ff @(posedge clk) begin
    if (reset) begin
      found_q       <= 1'b0;
      cur_max_q     <= '0;
      cur_idx_q     <= '0;
      peak_valid_q  <= 1'b0;
      peak_mag_q    <= '0;
      peak_index_q  <= '0;
      frame_count_q <= '0;
    end else begin
      found_q      <= found_d;
      cur_max_q    <= cur_max_d;
      cur_idx_q    <= cur_idx_d;
      peak_valid_q <= frame_end;
      if (frame_end) begin
        // Publish from the just-evaluated values so a following index-0 clear cannot race it.
        peak_mag_q    <= found_d ? cur_max_d : '0;
        peak_index_q  <= found_d ? cur_idx_d : '0;
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign mag_valid   = mag_valid_q;
  assign mag         = mag_q;
  assign mag_index   = mag_index_q;
  assign peak_valid  = peak_valid_q;
  assign peak_mag    = peak_mag_q;
  assign peak_index  = peak_index_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fft_mag_peak.sv
// Self-checking bench for fft_mag_peak: scoreboarded magnitude and peak outputs.
module tb_fft_mag_peak;

  localparam int N = 128;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               dv = 1'b0;
  logic [6:0]         xk_index = '0;
  logic signed [15:0] xk_re = '0;
  logic signed [15:0] xk_im = '0;
  logic               mag_valid;
  logic [31:0]        mag;
  logic [6:0]         mag_index;
  logic               peak_valid;
  logic [31:0]        peak_mag;
  logic [6:0]         peak_index;
  logic [15:0]        frame_count;

  fft_mag_peak #(
    .DATA_W (16),
    .INDEX_W(7),
    .MIN_BIN(1),
    .MAX_BIN(63)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dv         (dv),
    .xk_index   (xk_index),
    .xk_re      (xk_re),
    .xk_im      (xk_im),
    .mag_valid  (mag_valid),
    .mag        (mag),
    .mag_index  (mag_index),
    .peak_valid (peak_valid),
    .peak_mag   (peak_mag),
    .peak_index (peak_index),
    .frame_count(frame_count)
  );

  typedef struct {
    logic [31:0] mag;
    logic [6:0]  idx;
    int          cyc;
  } mag_exp_t;

  typedef struct {
    logic [31:0] mag;
    logic [6:0]  idx;
    logic [15:0] frames;
    int          cyc;
  } peak_exp_t;

  mag_exp_t    mag_sb[$];
  peak_exp_t   peak_sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          peak_seen = 0;
  int          exp_frames = 0;
  logic [31:0] last_mag = '0;
  logic [6:0]  last_idx = '0;
  int          frame_re[N];
  int          frame_im[N];

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference magnitude: saturating abs per component, then sum of squares.
  function automatic logic [31:0] model_mag(input int re, input int im);
    longint a, b;
    a = (re < 0) ? -longint'(re) : longint'(re);
    b = (im < 0) ? -longint'(im) : longint'(im);
    if (a > 32767) a = 32767;
    if (b > 32767) b = 32767;
    return 32'(a * a + b * b);
  endfunction

  // Scoreboard monitor: compares every mag_valid and peak_valid cycle against queued expectations.
  initial forever begin
    mag_exp_t  me;
    peak_exp_t pe;
    @(negedge clk);
    if (mag_valid === 1'b1) begin
      n_total++;
      if (mag_sb.size() == 0) begin
        $display("FAIL mag_unexpected: got mag_valid with mag=%0d idx=%0d, expected no output",
                 mag, mag_index);
      end else begin
        me = mag_sb.pop_front();
        if (mag !== me.mag || mag_index !== me.idx || (cyc - me.cyc) != 3) begin
          $display("FAIL mag_check: got mag=%0d idx=%0d lat=%0d, expected mag=%0d idx=%0d lat=3",
                   mag, mag_index, cyc - me.cyc, me.mag, me.idx);
        end else begin
          n_pass++;
        end
        last_mag = mag;
        last_idx = mag_index;
      end
    end
    if (peak_valid === 1'b1) begin
      peak_seen++;
      n_total++;
      if (peak_sb.size() == 0) begin
        $display("FAIL peak_unexpected: got peak_valid mag=%0d idx=%0d, expected no pulse",
                 peak_mag, peak_index);
      end else begin
        pe = peak_sb.pop_front();
        if (peak_mag !== pe.mag || peak_index !== pe.idx || frame_count !== pe.frames ||
            cyc != pe.cyc) begin
          $display("FAIL peak_check: got mag=%0d idx=%0d frames=%0d cyc=%0d, expected %0d %0d %0d %0d",
                   peak_mag, peak_index, frame_count, cyc, pe.mag, pe.idx, pe.frames, pe.cyc);
        end else begin
          n_pass++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog expired");
  end

  // One input cycle; valid samples are queued with their model result.
  task automatic drive(input logic v, input int idx, input int re, input int im);
    mag_exp_t e;
    @(posedge clk);
    #1;
    dv       = v;
    xk_index = 7'(idx);
    xk_re    = 16'(re);
    xk_im    = 16'(im);
    if (v && !reset) begin
      e.mag = model_mag(re, im);
      e.idx = 7'(idx);
      e.cyc = cyc;
      mag_sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    dv    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    mag_sb.delete();
    peak_sb.delete();
    exp_frames = 0;
  endtask

  task automatic set_all(input int re, input int im);
    for (int i = 0; i < N; i++) begin
      frame_re[i] = re;
      frame_im[i] = im;
    end
  endtask

  // Sends bins 0..N-1 in order and queues the expected peak from a window model.
  task automatic send_frame(input bit gaps);
    peak_exp_t   pe;
    bit          found;
    logic [31:0] mx, m;
    logic [6:0]  ix;
    found = 1'b0;
    mx    = '0;
    ix    = '0;
    for (int i = 0; i < N; i++) begin
      drive(1'b1, i, frame_re[i], frame_im[i]);
      pe.cyc = cyc;
      m = model_mag(frame_re[i], frame_im[i]);
      if (i >= 1 && i <= 63 && (!found || m > mx)) begin
        found = 1'b1;
        mx    = m;
        ix    = 7'(i);
      end
      if (gaps && i != N - 1) drive(1'b0, 0, 0, 0);
    end
    exp_frames++;
    pe.mag    = found ? mx : 32'd0;
    pe.idx    = found ? ix : 7'd0;
    pe.frames = 16'(exp_frames);
    pe.cyc    = pe.cyc + 4;
    peak_sb.push_back(pe);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      dv       = 1'b1;
      xk_index = 7'($urandom_range(0, 127));
      xk_re    = 16'($urandom);
      xk_im    = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_total += 4;
      if (mag_valid !== 1'b0 || mag !== 32'd0) begin
        $display("FAIL reset_mag: got valid=%b mag=%0d, expected 0/0", mag_valid, mag);
      end else n_pass++;
      if (mag_index !== 7'd0 || peak_valid !== 1'b0) begin
        $display("FAIL reset_idx: got idx=%0d pv=%b, expected 0/0", mag_index, peak_valid);
      end else n_pass++;
      if (peak_mag !== 32'd0 || peak_index !== 7'd0) begin
        $display("FAIL reset_peak: got %0d/%0d, expected 0/0", peak_mag, peak_index);
      end else n_pass++;
      if (frame_count !== 16'd0) begin
        $display("FAIL reset_frames: got %0d, expected 0", frame_count);
      end else n_pass++;
    end
    reset = 1'b0;
    dv    = 1'b0;
    mag_sb.delete();
    drive(1'b1, 9, 100, -200);
    idle(5);
    n_total++;
    if (last_mag !== 32'd50000 || last_idx !== 7'd9 || mag_sb.size() != 0) begin
      $display("FAIL reset_first: got mag=%0d idx=%0d pending=%0d, expected 50000/9/0",
               last_mag, last_idx, mag_sb.size());
    end else n_pass++;
  endtask

  task automatic test_saturation();
    drive(1'b1, 3, -32768, 0);
    idle(4);
    n_total++;
    if (last_mag !== 32'd1073676289 || last_idx !== 7'd3) begin
      $display("FAIL sat_min: got mag=%0d idx=%0d, expected 1073676289/3", last_mag, last_idx);
    end else n_pass++;
    drive(1'b1, 8, -3, 4);
    idle(4);
    n_total++;
    if (last_mag !== 32'd25) begin
      $display("FAIL sat_small: got mag=%0d, expected 25", last_mag);
    end else n_pass++;
    drive(1'b1, 2, -32768, -32768);
    idle(4);
    n_total++;
    if (last_mag !== 32'd2147352578) begin
      $display("FAIL sat_both: got mag=%0d, expected 2147352578", last_mag);
    end else n_pass++;
  endtask

  task automatic test_peak();
    int s0;
    do_reset(2);
    s0 = peak_seen;
    set_all(10, 10);
    frame_re[5] = 1000;
    frame_re[0] = 30000;
    send_frame(1'b0);
    idle(6);
    n_total++;
    if (peak_seen - s0 != 1 || peak_index !== 7'd5 || peak_mag !== 32'd1000100 ||
        frame_count !== 16'd1 || peak_valid !== 1'b0) begin
      $display("FAIL peak_basic: got pulses=%0d idx=%0d mag=%0d frames=%0d, expected 1/5/1000100/1",
               peak_seen - s0, peak_index, peak_mag, frame_count);
    end else n_pass++;
  endtask

  task automatic test_ties_window();
    do_reset(1);
    set_all(0, 0);
    frame_re[10] = 500;
    frame_re[20] = 500;
    frame_re[70] = 2000;
    send_frame(1'b0);
    idle(6);
    n_total++;
    if (peak_index !== 7'd10 || peak_mag !== 32'd250000 || frame_count !== 16'd1) begin
      $display("FAIL peak_ties: got idx=%0d mag=%0d frames=%0d, expected 10/250000/1",
               peak_index, peak_mag, frame_count);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s0;
    do_reset(1);
    s0 = peak_seen;
    set_all(1, 1);
    frame_re[7] = 300;
    send_frame(1'b1);
    set_all(2, 2);
    frame_re[40] = 700;
    send_frame(1'b0);
    idle(6);
    n_total++;
    if (peak_seen - s0 != 2 || frame_count !== 16'd2 || peak_index !== 7'd40 ||
        peak_mag !== 32'd490004) begin
      $display("FAIL b2b: got pulses=%0d frames=%0d idx=%0d mag=%0d, expected 2/2/40/490004",
               peak_seen - s0, frame_count, peak_index, peak_mag);
    end else n_pass++;
    set_all(0, 0);
    send_frame(1'b0);
    idle(6);
    n_total++;
    if (peak_mag !== 32'd0 || peak_index !== 7'd1 || frame_count !== 16'd3) begin
      $display("FAIL zero_frame: got mag=%0d idx=%0d frames=%0d, expected 0/1/3",
               peak_mag, peak_index, frame_count);
    end else n_pass++;
  endtask

  task automatic test_mid_reset();
    int s0;
    do_reset(1);
    s0 = peak_seen;
    set_all(5, 5);
    frame_re[30] = 900;
    for (int i = 0; i <= 60; i++) drive(1'b1, i, frame_re[i], frame_im[i]);
    do_reset(1);
    set_all(3, 3);
    frame_re[50] = 400;
    send_frame(1'b0);
    idle(6);
    n_total++;
    if (peak_seen - s0 != 1 || frame_count !== 16'd1 || peak_index !== 7'd50 ||
        peak_mag !== 32'd160009) begin
      $display("FAIL mid_reset: got pulses=%0d frames=%0d idx=%0d mag=%0d, expected 1/1/50/160009",
               peak_seen - s0, frame_count, peak_index, peak_mag);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_peak();
    test_ties_window();
    test_back_to_back();
    test_mid_reset();
    idle(4);
    n_total++;
    if (mag_sb.size() != 0 || peak_sb.size() != 0) begin
      $display("FAIL drain: got pending mag=%0d peak=%0d, expected 0/0",
               mag_sb.size(), peak_sb.size());
    end else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fft_mag_peak.md
# fft_mag_peak

Streaming magnitude-squared and per-frame peak detector for the FFT core's unloaded output. It sits between the FFT core's output port (dv, xk_index, xk_re, xk_im) and downstream audio analysis logic. It generalises the earlier combinational magnitude path into a registered, parametrised pipeline with explicit valid tagging and saturating absolute value. It also reports the strongest bin inside a configurable bin window once per frame.

## Interface
- DATA_W, 16, width of signed xk_re / xk_im (two's complement)
- INDEX_W, 7, width of xk_index; frame length N = 2^INDEX_W
- MIN_BIN, 1, lowest bin index eligible for peak search (1 excludes DC)
- MAX_BIN, 63, highest bin index eligible for peak search (N/2-1 by default); MIN_BIN <= MAX_BIN <= N-1

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- dv  in  1  input sample valid, from FFT core
- xk_index  in  INDEX_W  bin index of current sample
- xk_re  in  DATA_W  signed real part
- xk_im  in  DATA_W  signed imaginary part
- mag_valid  out  1  mag / mag_index valid this cycle
- mag  out  2*DATA_W  re^2 + im^2 of saturated absolute values, unsigned
- mag_index  out  INDEX_W  bin index aligned with mag
- peak_valid  out  1  one-cycle pulse: frame complete, peak outputs updated
- peak_mag  out  2*DATA_W  largest in-window mag of last completed frame
- peak_index  out  INDEX_W  bin index of peak_mag
- frame_count  out  16  completed frames since reset, wraps at 2^16

## Operation
- Stage 1 (abs): |x| per component; most-negative value (-2^(DATA_W-1)) saturates to 2^(DATA_W-1)-1. Result width DATA_W-1 bits unsigned.
- Stage 2 (square): re_abs^2 and im_abs^2 registered separately, each 2*DATA_W-2 bits.
- Stage 3 (sum): unsigned add, registered to mag, zero-extended to 2*DATA_W. Saturation guarantees no overflow; max = 2*(2^(DATA_W-1)-1)^2.
- dv, xk_index travel with data as a 3-deep valid/index shift register. The pipeline always advances; no stall, no back-pressure. Bubbles (dv=0) propagate as mag_valid=0. Data registers need not hold meaningful values when invalid.
- Peak tracker, acting on stage-3 output (mag_valid=1):
  - mag_index == 0: clear tracker (found flag=0, cur_max=0, cur_idx=0) before evaluating this bin. This handles restart after an incomplete frame.
  - Bin eligible if MIN_BIN <= mag_index <= MAX_BIN.
  - Eligible bin with found=0, or with mag strictly greater than cur_max: load cur_max=mag and cur_idx=mag_index, set found=1.
  - Ties keep the earlier (lower-arrival) bin.
  - mag_index == N-1: after evaluation, arm end-of-frame.
- End of frame, one cycle after the N-1 bin's mag_valid:
  - Copy cur_max / cur_idx to peak_mag / peak_index (0 / 0 if found=0).
  - Pulse peak_valid and increment frame_count.
  - peak_mag / peak_index hold until the next peak_valid.
- Bins may arrive in any order within a frame. Frame boundaries are defined only by index 0 (start) and N-1 (end). Duplicate indices are evaluated normally.
- A frame lacking index 0 extends the previous tracker state. A frame lacking index N-1 produces no peak_valid.

## Timing
- Reset: all outputs 0 (mag_valid, mag, mag_index, peak_valid, peak_mag, peak_index, frame_count); pipeline valids and tracker cleared. Reset applies on the same edge it is sampled, and a mid-frame reset discards all in-flight samples.
- Latency: sample accepted at edge t (dv=1) → mag_valid=1 with its mag in the cycle after edge t+3 (3 register stages).
- peak_valid asserts 1 cycle after the mag_valid of bin N-1 (4 cycles after the input edge of bin N-1), for exactly 1 cycle.
- Throughput: one sample per clock; back-to-back frames allowed. Index 0 of frame k+1 may immediately follow N-1 of frame k. That index-0 clear must not corrupt the peak being published for frame k, because publication uses the already-captured values.
- dv deasserted for any number of cycles: the pipeline drains, and the tracker holds state.
- Simultaneous reset and dv: reset wins, and the sample is dropped.

## Test plan
- Reset: hold reset 3 cycles with dv=1 and random data → all outputs 0; after release, the first mag_valid appears 3 cycles after the first dv.
- Saturation: single sample re=-32768, im=0, idx=3 → mag=1073676289 (32767^2), mag_index=3, exactly 3 cycles later. Also re=-3, im=4 → mag=25.
- Peak: full frame idx 0..127, all re=im=10 except idx 5 re=1000, idx 0 re=30000 → peak_valid 4 cycles after idx 127 enters, peak_index=5, peak_mag=1000100, frame_count=1. The DC bin is excluded.
- Ties and window: bins 10 and 20 both re=500, bin 70 re=2000 (outside MAX_BIN=63), others 0 → peak_index=10, peak_mag=250000.
- Gaps and back-to-back: frame 1 with dv toggling 1/0 each cycle, followed immediately by frame 2 gapless with its peak at bin 40 → two peak_valid pulses, values correct per frame, frame_count=2. Also check an all-zero frame gives peak_mag=0, peak_index=MIN_BIN.
- Mid-frame reset: assert reset after bin 60 of a frame, then send a complete frame → exactly one peak_valid, reflecting only the post-reset frame, frame_count=1.
